// File: rtl/video_border_crop_pkg.sv
// Shared types, default geometry and width helpers for the video border crop block.
package border_crop_pkg;

  localparam int unsigned PX_WIDTH_DEF = 10;
  localparam int unsigned CHANNELS_DEF = 3;
  localparam int unsigned IN_RES_X_DEF = 1924;
  localparam int unsigned IN_RES_Y_DEF = 1084;

  localparam int unsigned X_CNT_W = $clog2(IN_RES_X_DEF + 1);
  localparam int unsigned Y_CNT_W = $clog2(IN_RES_Y_DEF + 1);

  localparam int unsigned TID_W   = 4;
  localparam int unsigned TDEST_W = 4;

  typedef struct packed {
    logic long_line;
    logic short_line;
  } crop_err_t;

  // Counter width able to hold the saturation value res itself.
  function automatic int unsigned cnt_w(input int unsigned res);
    return $clog2(res + 1);
  endfunction

  function automatic int unsigned tdata_w(input int unsigned px, input int unsigned ch);
    return ((px * ch + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/video_border_crop_if.sv
// AXI4-Stream video interface: tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = border_crop_pkg::TID_W,
  parameter int unsigned DEST_W = border_crop_pkg::TDEST_W
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tuser;
  logic                  tlast;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tuser, tlast, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tuser, tlast, tid, tdest,
    output tready
  );
endinterface

// File: rtl/video_border_crop_out_reg.sv
// One-deep AXI4-Stream output register; only beats flagged keep_i are loaded,
// the rest are consumed without producing an output beat.
module crop_out_reg
  import border_crop_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  s_i,
  axi4_stream_if.master m_o,
  input  logic          keep_i,
  input  logic          sof_i,
  input  logic          eol_i,
  output logic          accept_o
);

  logic                valid_q, valid_d;
  logic                user_q, last_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W/8-1:0] strb_q, keep_q;
  logic [TID_W-1:0]    id_q;
  logic [TDEST_W-1:0]  dest_q;
  logic                ready;
  logic                load;

  assign ready    = !valid_q || m_o.tready;
  assign accept_o = s_i.tvalid && ready;
  assign load     = accept_o && keep_i;

  always_comb begin
    valid_d = valid_q;
    if (ready) valid_d = load;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      keep_q  <= '0;
      id_q    <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        user_q <= sof_i;
        last_q <= eol_i;
        data_q <= s_i.tdata;
        strb_q <= s_i.tstrb;
        keep_q <= s_i.tkeep;
        id_q   <= s_i.tid;
        dest_q <= s_i.tdest;
      end
    end
  end

  assign s_i.tready = ready;
  assign m_o.tvalid = valid_q;
  assign m_o.tuser  = user_q;
  assign m_o.tlast  = last_q;
  assign m_o.tdata  = data_q;
  assign m_o.tstrb  = strb_q;
  assign m_o.tkeep  = keep_q;
  assign m_o.tid    = id_q;
  assign m_o.tdest  = dest_q;

endmodule

// File: rtl/video_border_crop.sv
// Strips replicated border pixels from an extended video frame and regenerates SOF/EOL.
// Optional error statistics ports (err_flags_o, err_cnt_o) under `BORDER_CROP_STAT_EN.
module video_border_crop
  import border_crop_pkg::*;
#(
  parameter int unsigned PX_WIDTH = PX_WIDTH_DEF,
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned IN_RES_X = IN_RES_X_DEF,
  parameter int unsigned IN_RES_Y = IN_RES_Y_DEF,
  parameter int unsigned TOP      = 2,
  parameter int unsigned BOTTOM   = 2,
  parameter int unsigned LEFT     = 2,
  parameter int unsigned RIGHT    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  video_i,
  axi4_stream_if.master video_o
`ifdef BORDER_CROP_STAT_EN
  ,
  output logic [1:0]    err_flags_o,
  output logic [15:0]   err_cnt_o
`endif
);

  localparam int unsigned XW = cnt_w(IN_RES_X);
  localparam int unsigned YW = cnt_w(IN_RES_Y);

  localparam logic [XW-1:0] X_FIRST = XW'(LEFT);
  localparam logic [XW-1:0] X_END   = XW'(IN_RES_X - RIGHT);
  localparam logic [XW-1:0] X_LAST  = XW'(IN_RES_X - RIGHT - 1);
  localparam logic [XW-1:0] X_MAX   = XW'(IN_RES_X);
  localparam logic [YW-1:0] Y_FIRST = YW'(TOP);
  localparam logic [YW-1:0] Y_END   = YW'(IN_RES_Y - BOTTOM);
  localparam logic [YW-1:0] Y_MAX   = YW'(IN_RES_Y);

  logic [XW-1:0] x_q, x_d, x_eff;
  logic [YW-1:0] y_q, y_d, y_eff;
  logic          sync_q, sync_d;
  logic          keep, sof, eol, accept;

  // An input SOF overrides the counters before the keep decision, so a
  // mid-frame tuser abandons the partial frame. Until the first SOF after
  // reset the position is unknown and nothing is kept.
  always_comb begin
    x_eff = video_i.tuser ? '0 : x_q;
    y_eff = video_i.tuser ? '0 : y_q;
    keep  = (sync_q || video_i.tuser) &&
            (x_eff >= X_FIRST) && (x_eff < X_END) &&
            (y_eff >= Y_FIRST) && (y_eff < Y_END);
    sof   = keep && (x_eff == X_FIRST) && (y_eff == Y_FIRST);
    eol   = keep && ((x_eff == X_LAST) || video_i.tlast);

    x_d    = x_q;
    y_d    = y_q;
    sync_d = sync_q;
    if (accept) begin
      sync_d = sync_q || video_i.tuser;
      if (video_i.tlast) begin
        x_d = '0;
        y_d = (y_eff == Y_MAX) ? Y_MAX : y_eff + 1'b1;
      end else begin
        x_d = (x_eff == X_MAX) ? X_MAX : x_eff + 1'b1;
        y_d = y_eff;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      sync_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sync_q <= sync_d;
    end
  end

  crop_out_reg #(
    .DATA_W (tdata_w(PX_WIDTH, CHANNELS))
  ) u_out_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .s_i      (video_i),
    .m_o      (video_o),
    .keep_i   (keep),
    .sof_i    (sof),
    .eol_i    (eol),
    .accept_o (accept)
  );

`ifdef BORDER_CROP_STAT_EN
  localparam logic [XW-1:0] X_LINE_END = XW'(IN_RES_X - 1);

  crop_err_t   flags_q, flags_d;
  logic        line_long_q, line_long_d;
  logic [15:0] cnt_q, cnt_d;
  logic        short_hit, long_hit, line_err;

  // A line is counted once, at its tlast, if it was short or overran.
  always_comb begin
    short_hit   = accept && video_i.tlast && (x_eff < X_LINE_END);
    long_hit    = accept && (x_eff == X_MAX);
    line_err    = short_hit ||
                  (accept && video_i.tlast &&
                   ((line_long_q && !video_i.tuser) || long_hit));

    flags_d     = (accept && video_i.tuser) ? '0 : flags_q;
    flags_d.short_line = flags_d.short_line || short_hit;
    flags_d.long_line  = flags_d.long_line  || long_hit;

    line_long_d = line_long_q;
    if (accept) begin
      if (video_i.tlast) line_long_d = 1'b0;
      else               line_long_d = (line_long_q && !video_i.tuser) || long_hit;
    end

    cnt_d = (line_err && (cnt_q != '1)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q     <= '0;
      line_long_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      flags_q     <= flags_d;
      line_long_q <= line_long_d;
      cnt_q       <= cnt_d;
    end
  end

  assign err_flags_o = flags_q;
  assign err_cnt_o   = cnt_q;
`endif

endmodule

// File: tb/tb_video_border_crop.sv
// Directed bench for video_border_crop on an 8x6 extended frame with 1-pixel crops.
module tb_video_border_crop;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_W(32)) vin ();
  axi4_stream_if #(.DATA_W(32)) vout ();

`ifdef BORDER_CROP_STAT_EN
  logic [1:0]  err_flags;
  logic [15:0] err_cnt;
`endif

  video_border_crop #(
    .PX_WIDTH (10),
    .CHANNELS (3),
    .IN_RES_X (8),
    .IN_RES_Y (6),
    .TOP      (1),
    .BOTTOM   (1),
    .LEFT     (1),
    .RIGHT    (1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .video_i (vin),
    .video_o (vout)
`ifdef BORDER_CROP_STAT_EN
    ,
    .err_flags_o (err_flags),
    .err_cnt_o   (err_cnt)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic        l;
    logic        kept;
    logic        ou;
    logic        ol;
  } vec_t;

  int    n_vec = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  vec_t  tbl[48];
  int    rdy_mode = 0;
  logic  tgl = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sideband fields are derived from the data word so pass-through is checked too.
  function automatic logic [63:0] pack_beat(input beat_t b);
    logic [3:0] lo, hi;
    lo = b.d[3:0];
    hi = b.d[7:4];
    return {14'd0, b.d, b.u, b.l, lo, ~lo, lo, hi};
  endfunction

  always @(posedge clk) begin
    #1;
    tgl = ~tgl;
    case (rdy_mode)
      0:       vout.tready = 1'b1;
      1:       vout.tready = tgl;
      default: vout.tready = 1'b0;
    endcase
  end

  logic        stalled = 1'b0;
  logic [31:0] stall_d = '0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_hold_valid", {63'd0, vout.tvalid}, 64'd1);
        check("stall_hold_data", {32'd0, vout.tdata}, {32'd0, stall_d});
      end
      if (vout.tvalid && vout.tready) begin
        beat_t b;
        b.d = vout.tdata;
        b.u = vout.tuser;
        b.l = vout.tlast;
        obs_q.push_back(b);
        if (vout.tkeep !== vout.tdata[3:0] || vout.tstrb !== ~vout.tdata[3:0] ||
            vout.tid !== vout.tdata[3:0] || vout.tdest !== vout.tdata[7:4])
          obs_q[$].d = 32'hDEAD_BEEF;
      end
      stalled = vout.tvalid && !vout.tready;
      stall_d = vout.tdata;
    end
  end

  task automatic send(input logic [31:0] d, input logic u, input logic l);
    bit ok;
    int n;
    vin.tvalid = 1'b1;
    vin.tdata  = d;
    vin.tuser  = u;
    vin.tlast  = l;
    vin.tkeep  = d[3:0];
    vin.tstrb  = ~d[3:0];
    vin.tid    = d[3:0];
    vin.tdest  = d[7:4];
    ok = 1'b0;
    n  = 0;
    while (!ok) begin
      @(negedge clk);
      ok = vin.tready;
      @(posedge clk);
      #2;
      n++;
      if (!ok && n >= 64) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: beat %0h never accepted, required acceptance within 64 cycles", d);
        break;
      end
    end
    vin.tvalid = 1'b0;
  endtask

  task automatic send_line(input int base, input int len, input bit sof);
    for (int x = 0; x < len; x++) send(32'(base + x), sof && (x == 0), x == len - 1);
  endtask

  task automatic exp_line(input int first, input int n, input bit u);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = 32'(first + i);
      b.u = u && (i == 0);
      b.l = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic check_out(input string name);
    int n;
    repeat (6) @(posedge clk);
    #2;
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", name, i), pack_beat(obs_q[i]), pack_beat(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < 48; i++) begin
      send(tbl[i].d, tbl[i].u, tbl[i].l);
      if (tbl[i].kept) begin
        beat_t b;
        b.d = tbl[i].d;
        b.u = tbl[i].ou;
        b.l = tbl[i].ol;
        exp_q.push_back(b);
      end
    end
    check_out(name);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) begin
        int i;
        i = y * 8 + x;
        tbl[i].d    = 32'(i);
        tbl[i].u    = (i == 0);
        tbl[i].l    = (x == 7);
        tbl[i].kept = (x >= 1 && x <= 6 && y >= 1 && y <= 4);
        tbl[i].ou   = (x == 1 && y == 1);
        tbl[i].ol   = (x == 6);
      end

    vin.tvalid = 1'b0;
    vin.tdata  = '0;
    vin.tuser  = 1'b0;
    vin.tlast  = 1'b0;
    vin.tkeep  = '0;
    vin.tstrb  = '0;
    vin.tid    = '0;
    vin.tdest  = '0;

    // reset state
    #12;
    check("rst_tvalid", {63'd0, vout.tvalid}, 64'd0);
    check("rst_tuser",  {63'd0, vout.tuser},  64'd0);
    check("rst_tlast",  {63'd0, vout.tlast},  64'd0);
    check("rst_tdata",  {32'd0, vout.tdata},  64'd0);
`ifdef BORDER_CROP_STAT_EN
    check("rst_err_flags", {62'd0, err_flags}, 64'd0);
    check("rst_err_cnt",   {48'd0, err_cnt},   64'd0);
`endif
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;

    // 1: basic crop, continuous ready
    rdy_mode = 0;
    run_table("t1");

    // 2: same frame with toggling ready
    rdy_mode = 1;
    run_table("t2");
    rdy_mode = 0;

    // 3: short line 2 (tlast at x=4)
    send_line(0, 8, 1);
    send_line(8, 8, 0);
    send_line(16, 5, 0);
    for (int y = 3; y < 6; y++) send_line(y * 8, 8, 0);
    exp_line(9, 6, 1);
    exp_line(17, 4, 0);
    exp_line(25, 6, 0);
    exp_line(33, 6, 0);
    check_out("t3");
`ifdef BORDER_CROP_STAT_EN
    check("t3_err_flags", {62'd0, err_flags}, 64'b01);
    check("t3_err_cnt",   {48'd0, err_cnt},   64'd1);
`endif

    // 4: long line 3 (11 beats)
    send_line(0, 8, 1);
    send_line(8, 8, 0);
    send_line(16, 8, 0);
    send_line(24, 11, 0);
    send_line(32, 8, 0);
    send_line(40, 8, 0);
    exp_line(9, 6, 1);
    exp_line(17, 6, 0);
    exp_line(25, 6, 0);
    exp_line(33, 6, 0);
    check_out("t4");
`ifdef BORDER_CROP_STAT_EN
    check("t4_err_flags", {62'd0, err_flags}, 64'b10);
    check("t4_err_cnt",   {48'd0, err_cnt},   64'd2);
`endif

    // 5: new SOF arriving where line 3 should start
    send_line(0, 8, 1);
    send_line(8, 8, 0);
    send_line(16, 8, 0);
    for (int y = 0; y < 6; y++) send_line(100 + y * 8, 8, y == 0);
    exp_line(9, 6, 1);
    exp_line(17, 6, 0);
    exp_line(109, 6, 1);
    exp_line(117, 6, 0);
    exp_line(125, 6, 0);
    exp_line(133, 6, 0);
    check_out("t5");
`ifdef BORDER_CROP_STAT_EN
    check("t5_err_flags", {62'd0, err_flags}, 64'b00);
    check("t5_err_cnt",   {48'd0, err_cnt},   64'd2);
`endif

    // 6: asynchronous reset while an output beat is stalled
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send_line(0, 8, 1);
    send(32'd8, 1'b0, 1'b0);
    send(32'd9, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_valid_before_rst", {63'd0, vout.tvalid}, 64'd1);
    check("t6_data_before_rst",  {32'd0, vout.tdata},  64'd9);
    #1;
    rst = 1'b1;
    #1;
    check("t6_valid_async_clear", {63'd0, vout.tvalid}, 64'd0);
    check("t6_tuser_async_clear", {63'd0, vout.tuser},  64'd0);
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #2;
    for (int x = 2; x < 8; x++) send(32'(8 + x), 1'b0, x == 7);
    send_line(16, 8, 0);
    for (int y = 0; y < 6; y++) send_line(200 + y * 8, 8, y == 0);
    exp_line(209, 6, 1);
    exp_line(217, 6, 0);
    exp_line(225, 6, 0);
    exp_line(233, 6, 0);
    check_out("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
